serial_lane_scheduler: RTL and testbench

//  Round-robin byte scheduler in front of the parallel-to-serial lane; runs in the clk_4f domain.

---
 rtl/serial_lane_scheduler_pkg.sv | 15 +
 rtl/serial_lane_scheduler_if.sv | 29 ++
 rtl/serial_lane_scheduler_rr_arbiter.sv | 27 ++
 rtl/serial_lane_scheduler.sv | 132 +++++++++++++
 tb/tb_serial_lane_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_lane_scheduler_pkg.sv
// Purpose: shared constants and FSM state type for the serial lane scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_lane_scheduler_pkg;

    // K28.5 comma byte, sent on the lane whenever no data byte is valid.
    localparam logic [7:0] COM_SYM_DEF = 8'hBC;

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

endpackage

// File: rtl/serial_lane_scheduler_if.sv
// Purpose: requester-side handshake and serializer-side output bundle of the lane scheduler.
// Latency: n/a (wiring only).
// Backpressure: in_ready qualifies in_valid per requester; the serializer side has none.
// Ports: in_valid/in_data/in_last/in_ready per requester; data_out/valid_out to the
//        serializer; link_up and grant as status.
interface serial_lane_scheduler_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]   in_valid;
    logic [8*NUM_REQ-1:0] in_data;
    logic [NUM_REQ-1:0]   in_last;
    logic [NUM_REQ-1:0]   in_ready;
    logic [7:0]           data_out;
    logic                 valid_out;
    logic                 link_up;
    logic [NUM_REQ-1:0]   grant;

    // master: the requesters plus whoever watches the lane
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, data_out, valid_out, link_up, grant
    );

    // slave: the scheduler
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, data_out, valid_out, link_up, grant
    );
endinterface

// File: rtl/serial_lane_scheduler_rr_arbiter.sv
// Purpose: combinational round-robin pick, first requester at or above the pointer, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is taken.
// Ports: req (request vector), ptr_oh (one-hot search start), gnt (one-hot winner), gnt_vld.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] ptr_oh,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld
);
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        // Bits at or above the pointer position; if none of those request,
        // wrap around to the full request vector.
        upper_mask = ~(ptr_oh - NUM_REQ'(1));
        masked     = req & upper_mask;
        pick       = (|masked) ? masked : req;
        // Isolate the lowest set bit.
        gnt        = pick & (~pick + NUM_REQ'(1));
        gnt_vld    = |req;
    end
endmodule

// File: rtl/serial_lane_scheduler.sv
// Purpose: shares one serializer lane among NUM_REQ byte sources after link training.
// Latency: 1 cycle from accepted byte to data_out/valid_out.
// Backpressure: in_ready only for the granted requester in BURST; others must hold.
// Ports: clk_4f byte clock, reset async active-low, bus (requester handshake,
//        serializer data/valid, link_up, registered one-hot grant).
module serial_lane_scheduler
    import serial_lane_scheduler_pkg::*;
#(
    parameter int         NUM_REQ      = 2,
    parameter int         MAX_BURST    = 4,
    parameter int         TRAIN_CYCLES = 4,
    parameter logic [7:0] COM_SYM      = COM_SYM_DEF
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    serial_lane_scheduler_if.slave bus
);
    localparam int BCW = $clog2(MAX_BURST) + 1;
    localparam int TCW = $clog2(TRAIN_CYCLES + 1);

    state_e             state_q, state_d;
    logic [TCW-1:0]     train_cnt_q, train_cnt_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;       // one-hot search start (last_grant + 1)
    logic [7:0]         data_out_q, data_out_d;
    logic               valid_out_q, valid_out_d;
    logic               link_up_q, link_up_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_vld;
    logic [7:0]         sel_data;
    logic               sel_vld;
    logic               sel_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.in_valid),
        .ptr_oh  (ptr_q),
        .gnt     (arb_gnt),
        .gnt_vld (arb_vld)
    );

    // One-hot OR-mux of the owner's byte; grant_q is zero outside BURST.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = sel_data | bus.in_data[8*i +: 8];
            end
        end
        sel_vld  = |(bus.in_valid & grant_q);
        sel_last = |(bus.in_last & grant_q);
    end

    assign bus.in_ready  = (state_q == ST_BURST) ? grant_q : '0;
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.link_up   = link_up_q;
    assign bus.grant     = grant_q;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        link_up_d   = link_up_q;
        // Lane carries COM unless a byte is transferred this cycle.
        data_out_d  = COM_SYM;
        valid_out_d = 1'b0;

        case (state_q)
            ST_TRAIN: begin
                if (train_cnt_q == TCW'(TRAIN_CYCLES - 1)) begin
                    train_cnt_d = TCW'(TRAIN_CYCLES);
                    link_up_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    train_cnt_d = train_cnt_q + TCW'(1);
                end
            end
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d    = arb_gnt;
                    byte_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (sel_vld) begin
                    data_out_d  = sel_data;
                    valid_out_d = 1'b1;
                    // in_last and the burst cap coinciding is a single exit.
                    if (sel_last || (byte_cnt_q == BCW'(MAX_BURST - 1))) begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        byte_cnt_d = '0;
                        // Next search starts one past the requester just served.
                        ptr_d      = {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_TRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_TRAIN;
            train_cnt_q <= '0;
            byte_cnt_q  <= '0;
            grant_q     <= '0;
            ptr_q       <= NUM_REQ'(1);     // pointer at requester 0
            data_out_q  <= COM_SYM;
            valid_out_q <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            link_up_q   <= link_up_d;
        end
    end
endmodule

// File: tb/tb_serial_lane_scheduler.sv
// Purpose: self-checking bench for serial_lane_scheduler against a cycle-level reference model.
// Latency: n/a.
// Backpressure: requesters hold each byte until the scheduler accepts it.
module tb_serial_lane_scheduler;
    import serial_lane_scheduler_pkg::*;

    localparam int         N   = 2;
    localparam int         MB  = 4;
    localparam int         TC  = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    serial_lane_scheduler_if #(.NUM_REQ(N)) bus ();

    serial_lane_scheduler #(
        .NUM_REQ(N), .MAX_BURST(MB), .TRAIN_CYCLES(TC), .COM_SYM(COM)
    ) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Requester byte queues: {last, data}. Head is presented while non-empty.
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    bit          hold1;       // requester 1 withholds valid for one cycle
    bit          drop_once;   // arm: withhold once after the next byte of requester 1 is taken
    logic [10:0] tr[$];       // lane trace: {grant, valid_out, data_out} per cycle
    logic [10:0] exp_q[$];

    // Reference model: who owns the lane, how many bytes it has sent, where the next search starts.
    int         m_tcnt, m_owner, m_sent, m_start;
    bit         m_link, m_vld;
    logic [7:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [10:0] e(input logic [1:0] g, input logic v, input logic [7:0] d);
        return {g, v, d};
    endfunction

    task automatic model_reset();
        m_tcnt = 0; m_owner = -1; m_sent = 0; m_start = 0;
        m_link = 1'b0; m_vld = 1'b0; m_data = COM;
    endtask

    // One clock edge of the model; acc reports which requester's byte was consumed.
    task automatic model_edge(output logic [N-1:0] acc);
        bit found;
        int c;
        acc = '0;
        if (!reset) begin
            model_reset();
            return;
        end
        m_vld  = 1'b0;
        m_data = COM;
        if (!m_link) begin
            m_tcnt++;
            if (m_tcnt == TC) m_link = 1'b1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_start + k) % N;
                if (!found && bus.in_valid[c]) begin
                    found = 1'b1; m_owner = c; m_sent = 0;
                end
            end
        end else if (bus.in_valid[m_owner]) begin
            acc[m_owner] = 1'b1;
            m_data = bus.in_data[8*m_owner +: 8];
            m_vld  = 1'b1;
            m_sent++;
            if (bus.in_last[m_owner] || m_sent == MB) begin
                m_start = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic model_compare();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("data_out",  32'(bus.data_out),  32'(m_data));
        chk("valid_out", 32'(bus.valid_out), 32'(m_vld));
        chk("link_up",   32'(bus.link_up),   32'(m_link));
        chk("grant",     32'(bus.grant),     32'(eg));
        chk("in_ready",  32'(bus.in_ready),  32'(eg));
        chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        chk("ready_within_grant", 32'(bus.in_ready & ~bus.grant), 32'd0);
        chk("com_when_invalid", 32'(bus.valid_out ? COM : bus.data_out), 32'(COM));
    endtask

    task automatic drive();
        bus.in_valid[0]  = (q0.size() != 0);
        bus.in_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        bus.in_last[0]   = (q0.size() != 0) ? q0[0][8] : 1'b0;
        bus.in_valid[1]  = (q1.size() != 0) && !hold1;
        bus.in_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        bus.in_last[1]   = (q1.size() != 0) ? q1[0][8] : 1'b0;
    endtask

    // One cycle: model sees the edge, then 1 time unit later inputs advance and outputs are checked.
    task automatic step();
        logic [N-1:0] acc;
        @(posedge clk_4f);
        model_edge(acc);
        #1;
        hold1 = 1'b0;
        if (acc[0] && q0.size() != 0) void'(q0.pop_front());
        if (acc[1] && q1.size() != 0) begin
            void'(q1.pop_front());
            if (drop_once) begin
                drop_once = 1'b0;
                hold1     = 1'b1;
            end
        end
        drive();
        tr.push_back({bus.grant, bus.valid_out, bus.data_out});
        model_compare();
    endtask

    task automatic do_reset();
        int n;
        q0.delete(); q1.delete();
        hold1 = 1'b0; drop_once = 1'b0;
        drive();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_data_out",  32'(bus.data_out),  32'(COM));
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_link_up",   32'(bus.link_up),   32'd0);
        chk("rst_grant",     32'(bus.grant),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        repeat (3) step();
        @(negedge clk_4f);
        reset = 1'b1;
        n = 0;
        while (!bus.link_up && n < 20) begin
            step();
            n++;
        end
        chk("train_cycles", 32'(n), 32'(TC));
    endtask

    // Compare the trace from its first valid byte against exp_q.
    task automatic check_trace(input string nm);
        int s;
        s = -1;
        for (int i = 0; i < tr.size(); i++) begin
            if (s < 0 && tr[i][8]) s = i;
        end
        if (s < 0 || s + exp_q.size() > tr.size()) begin
            total++;
            bad++;
            $display("FAIL %s: trace too short (start %0d, size %0d), want %0d entries",
                     nm, s, tr.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                chk($sformatf("%s[%0d]", nm, i), 32'(tr[s+i]), 32'(exp_q[i]));
            end
        end
    endtask

    initial begin
        logic [1:0] own [4];
        logic [7:0] base [4];
        int n;

        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_last  = '0;
        #2;

        // Single requester, three-byte burst ending on in_last.
        do_reset();
        q0.push_back(9'h0AB); q0.push_back(9'h0CA); q0.push_back(9'h112);
        drive();
        tr.delete();
        repeat (10) step();
        exp_q.delete();
        exp_q.push_back(e(2'b01, 1'b1, 8'hAB));
        exp_q.push_back(e(2'b01, 1'b1, 8'hCA));
        exp_q.push_back(e(2'b00, 1'b1, 8'h12));
        exp_q.push_back(e(2'b00, 1'b0, COM));
        check_trace("single_burst");

        // Both always valid, no last: MAX_BURST forces alternation with one COM gap.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q0.push_back(9'(k + 8'h01));
            q1.push_back(9'(k + 8'h11));
        end
        drive();
        tr.delete();
        repeat (30) step();
        own  = '{2'b01, 2'b10, 2'b01, 2'b10};
        base = '{8'h01, 8'h11, 8'h05, 8'h15};
        exp_q.delete();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(e((j < 3) ? own[b] : 2'b00, 1'b1, 8'(base[b] + 8'(j))));
            end
            exp_q.push_back(e((b < 3) ? own[(b + 1) % 4] : 2'b00, 1'b0, COM));
        end
        check_trace("max_burst_rr");

        // Owner withholds valid for one cycle mid-burst: bubble, grant held.
        do_reset();
        q1.push_back(9'h0DC); q1.push_back(9'h0FA); q1.push_back(9'h133);
        drop_once = 1'b1;
        drive();
        tr.delete();
        repeat (12) step();
        exp_q.delete();
        exp_q.push_back(e(2'b10, 1'b1, 8'hDC));
        exp_q.push_back(e(2'b10, 1'b0, COM));
        exp_q.push_back(e(2'b10, 1'b1, 8'hFA));
        exp_q.push_back(e(2'b00, 1'b1, 8'h33));
        exp_q.push_back(e(2'b00, 1'b0, COM));
        check_trace("bubble");

        // Reset asserted mid-transfer, then retrain; requester 0 wins first afterwards.
        do_reset();
        for (int k = 0; k < 8; k++) q0.push_back(9'(k + 8'h60));
        drive();
        n = 0;
        while (!bus.valid_out && n < 20) begin
            step();
            n++;
        end
        chk("burst_started_before_reset", 32'(bus.valid_out), 32'd1);
        #2;
        do_reset();
        q0.push_back(9'h041); q0.push_back(9'h142);
        q1.push_back(9'h151);
        drive();
        tr.delete();
        repeat (12) step();
        exp_q.delete();
        exp_q.push_back(e(2'b01, 1'b1, 8'h41));
        exp_q.push_back(e(2'b00, 1'b1, 8'h42));
        exp_q.push_back(e(2'b10, 1'b0, COM));
        exp_q.push_back(e(2'b00, 1'b1, 8'h51));
        exp_q.push_back(e(2'b00, 1'b0, COM));
        check_trace("after_retrain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
